// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, per-frame key classification, press/release
// debouncing and a three-digit BCD entry register fed by the accepted keys.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic [3:0]  Col,
  output logic [3:0]  Row,
  output logic [3:0]  KEY,
  output logic        VALID,
  output logic        PRESSED,
  output logic [11:0] BCD
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB      = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HELD,
    ST_RELEASE
  } state_e;

  // Column synchronizer
  logic [3:0]  col_s1_q, col_s2_q;

  // Scan timing
  logic [15:0] div_q, div_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic        slot_end, frame_end;

  // Per-frame accumulation of what the columns showed
  logic        seen_q, seen_d, seen_n;
  logic        multi_q, multi_d, multi_n;
  logic [3:0]  code_q, code_d, code_n;
  logic [1:0]  col_idx;

  // Debounce FSM and registered outputs
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  key_q, key_d;
  logic        valid_q, valid_d;
  logic        pressed_q, pressed_d;
  logic [11:0] bcd_q, bcd_d;
  logic        frame_none, frame_single;
  logic        accept;
  logic [3:0]  acc_code;

  always_comb begin : scan_comb
    slot_end  = (div_q == DIV_LAST);
    frame_end = slot_end && (row_idx_q == 2'd3);
    div_d     = slot_end ? 16'd0 : div_q + 16'd1;
    row_idx_d = slot_end ? row_idx_q + 2'd1 : row_idx_q;

    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (col_s2_q[i]) col_idx = 2'(i);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    seen_n  = seen_q;
    multi_n = multi_q;
    code_n  = code_q;
    // Columns are only trusted on the last cycle of a slot, after the row drive has settled.
    if (slot_end && (col_s2_q != 4'd0)) begin
      if (seen_q || !$onehot(col_s2_q)) begin
        multi_n = 1'b1;
      end else begin
        seen_n = 1'b1;
        code_n = {row_idx_q, col_idx};
      end
    end

    seen_d  = frame_end ? 1'b0 : seen_n;
    multi_d = frame_end ? 1'b0 : multi_n;
    code_d  = frame_end ? 4'd0 : code_n;

    frame_none   = !seen_n;
    frame_single = seen_n && !multi_n;
  end

  always_comb begin : fsm_comb
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    bcd_d     = bcd_q;
    accept    = 1'b0;
    acc_code  = cand_q;

    if (frame_end) begin
      unique case (state_q)
        ST_IDLE: begin
          // A multi-key frame is treated as empty until a key has been accepted.
          if (frame_single) begin
            cand_d = code_n;
            cnt_d  = 4'd1;
            if (DEBOUNCE == 1) begin
              accept   = 1'b1;
              acc_code = code_n;
            end else begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (frame_single && (code_n == cand_q)) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) accept = 1'b1;
          end else if (frame_single) begin
            cand_d = code_n;
            cnt_d  = 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (frame_none) begin
            cnt_d = 4'd1;
            if (DEBOUNCE == 1) begin
              state_d   = ST_IDLE;
              pressed_d = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (frame_none) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) begin
              state_d   = ST_IDLE;
              pressed_d = 1'b0;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (accept) begin
      state_d   = ST_HELD;
      key_d     = acc_code;
      pressed_d = 1'b1;
      valid_d   = 1'b1;
      if (acc_code <= 4'd9) begin
        bcd_d = {bcd_q[7:0], acc_code};
      end else if (acc_code == 4'hB) begin
        bcd_d = {4'h0, bcd_q[11:4]};
      end else if (acc_code == 4'hC) begin
        bcd_d = 12'h000;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (Reset) begin
      col_s1_q  <= 4'd0;
      col_s2_q  <= 4'd0;
      div_q     <= 16'd0;
      row_idx_q <= 2'd0;
      seen_q    <= 1'b0;
      multi_q   <= 1'b0;
      code_q    <= 4'd0;
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      cand_q    <= 4'd0;
      key_q     <= 4'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      bcd_q     <= 12'h000;
    end else begin
      col_s1_q  <= Col;
      col_s2_q  <= col_s1_q;
      div_q     <= div_d;
      row_idx_q <= row_idx_d;
      seen_q    <= seen_d;
      multi_q   <= multi_d;
      code_q    <= code_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
      bcd_q     <= bcd_d;
    end
  end

  assign Row     = 4'b0001 << row_idx_q;
  assign KEY     = key_q;
  assign VALID   = valid_q;
  assign PRESSED = pressed_q;
  assign BCD     = bcd_q;

endmodule
